mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Final stage of the 4-stage MIPS pipeline, directly downstream of the EX stage. Consumes the EX
//  outputs (ALU result, dest reg, PC+4, 11-bit control) plus store data.
//  Performs the data-memory load/store against an internal word RAM and drives the register-file
//  write port. Loads take MEM_LAT cycles and stall upstream via a small FSM.
// PARAMETERS
//  SIZE     32   datapath width; register index width is $clog2(SIZE)
//  DEPTH    256  data-memory words; address index = ALUresult[$clog2(DEPTH)+1:2]
//  MEM_LAT  2    load latency in cycles, >=1
// PORTS
//  clk           in   1             pipeline clock, rising edge
//  rst_n         in   1             asynchronous active-low reset
//  valid_EX      in   1             EX outputs hold a live instruction this cycle
//  ALUresult     in   SIZE          address (ld/st) or result (R-type)
//  storeData_EX  in   SIZE          rt value for stores
//  writeReg_EX   in   $clog2(SIZE)  destination register
//  PC_4_EX       in   SIZE          PC+4, link value for jal
//  control_EX    in   11            control word from EX
//  regWrite_WB   out  1             register-file write enable, one-cycle pulse
//  writeReg_WB   out  $clog2(SIZE)  register-file write index
//  writeData_WB  out  SIZE          register-file write data
//  stall_MEM     out  1             upstream must hold its outputs this cycle
// BEHAVIOUR
//  - Control map: [10]RegWrite [9]MemToReg [8]MemRead [7]MemWrite [6]Branch [5:3]ALUOp
//    [2]ALUSrc [1]RegDst [0]Jump. Only [10:7] and [0] are used here.
//  - Reset (async, rst_n low): regWrite_WB=0, writeReg_WB=0, writeData_WB=0, stall_MEM=0,
//    FSM=IDLE, cnt=0. Memory contents are not reset.
//  - Inputs are accepted only at a rising edge with valid_EX=1 and the FSM in IDLE.
//  - FSM, IDLE, non-load accepted:
//    - Store (MemWrite): mem[idx] <= storeData_EX at the accept edge; regWrite_WB=0 next cycle.
//    - R-type: writeData_WB <= ALUresult.
//    - Jump with RegWrite: writeData_WB <= PC_4_EX.
//    - For these, regWrite_WB <= RegWrite at the same edge; latency is 1 cycle.
//  - FSM, IDLE, load accepted (MemRead):
//    - Latch the index, dest reg, and the 5 used control bits.
//    - MEM_LAT=1: writeData_WB <= mem[idx] and regWrite_WB <= 1 at the accept edge; stay IDLE.
//    - MEM_LAT>1: go to WAIT with cnt=MEM_LAT-1; stall_MEM=1 (registered) and regWrite_WB=0.
//  - FSM, WAIT: cnt decrements each edge. At the edge where cnt==1, load writeback from the
//    latched index/reg, set regWrite_WB=1, stall_MEM=0, and go to IDLE. Inputs in WAIT are ignored.
//  - Simultaneous MemRead and MemWrite: treated as a store; no load occurs.
//  - regWrite_WB is forced 0 whenever writeReg is 0.
//  - regWrite_WB is 0 on every cycle that has no completing write; the other outputs hold their
//    last values.
//  - Reset asserted during WAIT: the load is abandoned, no writeback occurs, and outputs are reset.
//  - Address bits above the index width are ignored, so the address wraps modulo DEPTH.
// CONFIGURATION
//  - Macro MEM_MISALIGN_TRAP_EN:
//    - Defined: adds output misalign_MEM (1 bit, reset 0). It pulses 1 for one cycle on an accepted
//      load/store with ALUresult[1:0]!=0. That access is suppressed: no memory write, no
//      regWrite_WB, no WAIT entry.
//    - Undefined: ALUresult[1:0] is ignored, the port is absent, and accesses proceed aligned-down.
// STRUCTURE
//  - Package mips_pkg: control-bit index localparams (CTL_REGWRITE=10 ... CTL_JUMP=0) and the FSM
//    state enum {IDLE, WAIT}.
//  - Sub-module dmem_ram: a parameterised word RAM with a synchronous write and a combinational
//    read, instantiated once.
// TESTING
//  - Reset:
//    - Stimulus: hold rst_n=0 with random inputs.
//    - Response: all outputs 0; they stay 0 for 3 cycles after release while valid_EX=0.
//  - R-type:
//    - Stimulus: valid_EX=1, ALUresult=0x0000_002A, writeReg_EX=5, control RegWrite only.
//    - Response: next cycle regWrite_WB=1, writeReg_WB=5, writeData_WB=0x2A, stall_MEM=0.
//  - Store then load, MEM_LAT=2:
//    - Stimulus: sw 0xDEADBEEF to addr 0x10, then lw from 0x10 into r8.
//    - Response: stall_MEM=1 for exactly 1 cycle; then regWrite_WB=1, writeReg_WB=8,
//      writeData_WB=0xDEADBEEF.
//  - jal link and r0:
//    - Stimulus: Jump+RegWrite, PC_4_EX=0x104, writeReg_EX=31; then an R-type to writeReg_EX=0.
//    - Response: writeData_WB=0x104 with regWrite_WB=1 for the jal; regWrite_WB=0 for the r0 write.
//  - Reset mid-load, MEM_LAT=4:
//    - Stimulus: assert rst_n=0 during the 2nd WAIT cycle.
//    - Response: no regWrite_WB pulse; stall_MEM=0 immediately; FSM=IDLE after release.
//  - Wrap and misalign:
//    - Stimulus: store to 0x400 with DEPTH=256; load from 0x000; and a load at 0x13.
//    - Response: the 0x000 load reads the stored value. For 0x13: with MEM_MISALIGN_TRAP_EN,
//      misalign_MEM=1 and no write; without it, the load reads from 0x10.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline back end: control-word bit positions and
// the MEM/WB load FSM state type.
package mips_pkg;

  localparam int unsigned CTL_REGWRITE = 10;
  localparam int unsigned CTL_MEMTOREG = 9;
  localparam int unsigned CTL_MEMREAD  = 8;
  localparam int unsigned CTL_MEMWRITE = 7;
  localparam int unsigned CTL_BRANCH   = 6;
  localparam int unsigned CTL_JUMP     = 0;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } mem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data memory: synchronous write, combinational read, no reset of contents.
module dmem_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory load/store and register-file write port, with a load-latency
// stall FSM. Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_EX,
  input  logic [SIZE-1:0]         ALUresult,
  input  logic [SIZE-1:0]         storeData_EX,
  input  logic [$clog2(SIZE)-1:0] writeReg_EX,
  input  logic [SIZE-1:0]         PC_4_EX,
  input  logic [10:0]             control_EX,
  output logic                    regWrite_WB,
  output logic [$clog2(SIZE)-1:0] writeReg_WB,
  output logic [SIZE-1:0]         writeData_WB,
  output logic                    stall_MEM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                    misalign_MEM
`endif
);

  localparam int unsigned RegW = $clog2(SIZE);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mem_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [RegW-1:0] reg_q;

  logic            accept, is_store, is_load, bad_align, ram_we;
  logic [IdxW-1:0] idx, rd_idx;
  logic [SIZE-1:0] rd_data;

  // Upper address bits drop out so the address wraps modulo DEPTH.
  assign idx      = ALUresult[IdxW+1:2];
  assign accept   = valid_EX && (state_q == IDLE);
  assign is_store = control_EX[CTL_MEMWRITE];
  assign is_load  = control_EX[CTL_MEMREAD] && !control_EX[CTL_MEMWRITE];

`ifdef MEM_MISALIGN_TRAP_EN
  assign bad_align = (is_store || is_load) && (ALUresult[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  assign ram_we = accept && is_store && !bad_align;
  assign rd_idx = (state_q == WAIT) ? idx_q : idx;

  logic unused_bits;
  assign unused_bits = ^{ALUresult[SIZE-1:IdxW+2], ALUresult[1:0],
                         control_EX[CTL_MEMTOREG], control_EX[CTL_BRANCH:1]};

  dmem_ram #(
    .Width(SIZE),
    .Depth(DEPTH)
  ) u_dmem (
    .clk  (clk),
    .we   (ram_we),
    .waddr(idx),
    .wdata(storeData_EX),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      reg_q        <= '0;
      regWrite_WB  <= 1'b0;
      writeReg_WB  <= '0;
      writeData_WB <= '0;
      stall_MEM    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_MEM <= 1'b0;
`endif
    end else begin
      regWrite_WB <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_MEM <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (bad_align) begin
`ifdef MEM_MISALIGN_TRAP_EN
              misalign_MEM <= 1'b1;
`endif
            end else if (is_load) begin
              idx_q <= idx;
              reg_q <= writeReg_EX;
              if (MEM_LAT == 1) begin
                writeReg_WB  <= writeReg_EX;
                writeData_WB <= rd_data;
                regWrite_WB  <= |writeReg_EX;
              end else begin
                state_q   <= WAIT;
                cnt_q     <= CntW'(MEM_LAT - 1);
                stall_MEM <= 1'b1;
              end
            end else if (!is_store && control_EX[CTL_REGWRITE]) begin
              writeReg_WB  <= writeReg_EX;
              writeData_WB <= control_EX[CTL_JUMP] ? PC_4_EX : ALUresult;
              regWrite_WB  <= |writeReg_EX;
            end
          end
        end
        WAIT: begin
          if (cnt_q == CntW'(1)) begin
            writeReg_WB  <= reg_q;
            writeData_WB <= rd_data;
            regWrite_WB  <= |reg_q;
            stall_MEM    <= 1'b0;
            cnt_q        <= '0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule
